// File: rtl/halfband_cascade_ctrl.sv
// ---------------------------------------------------------------------------
// halfband_cascade_ctrl
//
// Control sequencer for a cascade of decimate-by-2 halfband stages that all
// share one multiply-accumulate engine and one sample buffer.  Every stage
// owns a 16-entry ring in the buffer.  Two writes into a stage form a pair,
// and each completed pair requests one 7-tap evaluation of that stage.  The
// result of stage s is written back into stage s+1.  The result of the last
// stage is flagged on ov.
//
// Parameters
//   NSTAGES  number of cascaded stages (1..8)
//   MACLAT   cycles from a tap read issue to its product in the accumulator
//
// Ports
//   c          clock, rising edge
//   reset      synchronous active-high reset
//   iv         external input word valid (written into stage 0)
//   bram_we    sample buffer write enable
//   bram_wsel  write data select: 0 = external word, 1 = filter result
//   bram_wa    write address {2'b0, stage[2:0], idx[3:0]}
//   bram_re    read enable during tap cycles
//   bram_ra    read address, same format as bram_wa
//   coefa      coefficient ROM index, aligned with bram_ra
//   mac_first  first tap of an evaluation (accumulator loads)
//   res_v      one-cycle filter result valid
//   res_stage  stage that produced the result flagged by res_v
//   ov         one-cycle final-stage result valid
//   overrun    sticky: an evaluation request was dropped
//   busy       sequencer active or a result still in flight
// ---------------------------------------------------------------------------
module halfband_cascade_ctrl #(
    parameter int NSTAGES = 4,
    parameter int MACLAT  = 4
) (
    input  logic       c,
    input  logic       reset,
    input  logic       iv,
    output logic       bram_we,
    output logic       bram_wsel,
    output logic [8:0] bram_wa,
    output logic       bram_re,
    output logic [8:0] bram_ra,
    output logic [1:0] coefa,
    output logic       mac_first,
    output logic       res_v,
    output logic [2:0] res_stage,
    output logic       ov,
    output logic       overrun,
    output logic       busy
);

    localparam logic [2:0] LAST = 3'(NSTAGES - 1);

    typedef enum logic [2:0] {
        IDLE, T0, T1, T2, T3, T4, T5, T6
    } state_t;

    state_t              state;
    logic [2:0]          cur_stage;
    logic [3:0]          newest;
    logic [3:0]          wp [8];
    logic [7:0]          tog;
    logic [7:0]          pending;
    logic                def_v;
    logic [2:0]          def_stage;
    logic [MACLAT-1:0]   tag_v;
    logic [2:0]          tag_s [MACLAT];

    logic                wr_ext;
    logic                fb_now;
    logic                wr_en;
    logic                wr_fb;
    logic [2:0]          wr_stage;
    logic [2:0]          sel;
    logic [7:0]          set_mask;
    logic [7:0]          clr_mask;
    logic [3:0]          tap_off;

    assign res_v     = tag_v[MACLAT-1];
    assign res_stage = tag_s[MACLAT-1];
    assign ov        = res_v && (res_stage == LAST);
    assign busy      = (state != IDLE) || (|tag_v) || def_v;

    // Write port arbitration.  The external word always wins; a feedback
    // result that loses the port is parked in def_v and written next cycle
    // (the iv spacing guarantees the port is free then).  Nothing is written
    // while reset is asserted, so in-flight results are discarded.
    always_comb begin
        wr_ext   = iv && !reset;
        fb_now   = res_v && (res_stage != LAST) && !reset;
        wr_en    = 1'b0;
        wr_fb    = 1'b0;
        wr_stage = 3'd0;
        if (wr_ext) begin
            wr_en    = 1'b1;
        end else if (def_v && !reset) begin
            wr_en    = 1'b1;
            wr_fb    = 1'b1;
            wr_stage = def_stage;
        end else if (fb_now) begin
            wr_en    = 1'b1;
            wr_fb    = 1'b1;
            wr_stage = res_stage + 3'd1;
        end
        bram_we   = wr_en;
        bram_wsel = wr_fb;
        bram_wa   = wr_en ? {2'b00, wr_stage, wp[wr_stage]} : 9'd0;
    end

    // A write that returns a stage's toggle to 0 completes a pair and raises
    // that stage's request.  In IDLE the lowest pending stage is granted.
    always_comb begin
        set_mask = (wr_en && tog[wr_stage]) ? (8'd1 << wr_stage) : 8'd0;
        sel      = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (pending[i]) sel = 3'(i);
        end
        clr_mask = ((state == IDLE) && (|pending)) ? (8'd1 << sel) : 8'd0;
    end

    // Tap pattern relative to the newest sample n: n-10, n-8, n-6, n-5, n-4,
    // n-2, n, expressed as mod-16 offsets with the symmetric coefficients.
    always_comb begin
        tap_off = 4'd0;
        coefa   = 2'd0;
        case (state)
            T0:      begin tap_off = 4'd6;  coefa = 2'd0; end
            T1:      begin tap_off = 4'd8;  coefa = 2'd1; end
            T2:      begin tap_off = 4'd10; coefa = 2'd2; end
            T3:      begin tap_off = 4'd11; coefa = 2'd3; end
            T4:      begin tap_off = 4'd12; coefa = 2'd2; end
            T5:      begin tap_off = 4'd14; coefa = 2'd1; end
            default: begin tap_off = 4'd0;  coefa = 2'd0; end
        endcase
        bram_re   = (state != IDLE);
        bram_ra   = bram_re ? {2'b00, cur_stage, newest + tap_off} : 9'd0;
        mac_first = (state == T0);
    end

    // Sequencer, ring pointers, request bits and the result tag pipeline.
    // The tag pipeline is MACLAT deep so a tag entered after T6 emerges
    // exactly when the accumulator holds the finished sum.
    always_ff @(posedge c) begin
        if (reset) begin
            state     <= IDLE;
            cur_stage <= 3'd0;
            newest    <= 4'd0;
            tog       <= 8'd0;
            pending   <= 8'd0;
            overrun   <= 1'b0;
            def_v     <= 1'b0;
            def_stage <= 3'd0;
            tag_v     <= '0;
            for (int i = 0; i < 8; i++) wp[i] <= 4'd0;
            for (int i = 0; i < MACLAT; i++) tag_s[i] <= 3'd0;
        end else begin
            if (wr_en) begin
                wp[wr_stage]  <= wp[wr_stage] + 4'd1;
                tog[wr_stage] <= ~tog[wr_stage];
            end
            pending <= (pending & ~clr_mask) | set_mask;
            if (|(set_mask & pending)) overrun <= 1'b1;
            def_v     <= wr_ext && fb_now;
            def_stage <= res_stage + 3'd1;

            tag_v    <= {tag_v[MACLAT-2:0], (state == T6)};
            tag_s[0] <= (state == T6) ? cur_stage : 3'd0;
            for (int i = 1; i < MACLAT; i++) tag_s[i] <= tag_s[i-1];

            case (state)
                IDLE: begin
                    if (|pending) begin
                        state     <= T0;
                        cur_stage <= sel;
                        newest    <= wp[sel] - 4'd1;
                    end
                end
                T0:      state <= T1;
                T1:      state <= T2;
                T2:      state <= T3;
                T3:      state <= T4;
                T4:      state <= T5;
                T5:      state <= T6;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_halfband_cascade_ctrl.sv
// ---------------------------------------------------------------------------
// tb_halfband_cascade_ctrl
//
// Directed bench for halfband_cascade_ctrl.  Two instances share clock,
// reset and iv: dut uses the default 4 stages, dut2 uses 2 stages so the
// final-stage path can be observed early.  Cycle 0 of each scenario is the
// first cycle with reset low; inputs are driven 2 time units after the
// rising edge and outputs are sampled 1 unit later.
// ---------------------------------------------------------------------------
module tb_halfband_cascade_ctrl;

    localparam int MACLAT = 4;

    logic       c;
    logic       reset;
    logic       iv;

    logic       we, wsel, re, mf, rv, ov, ovr, busy;
    logic [8:0] wa, ra;
    logic [1:0] coefa;
    logic [2:0] rs;

    logic       we2, wsel2, re2, mf2, rv2, ov2, ovr2, busy2;
    logic [8:0] wa2, ra2;
    logic [1:0] coefa2;
    logic [2:0] rs2;

    int checks;
    int errors;

    halfband_cascade_ctrl #(.NSTAGES(4), .MACLAT(MACLAT)) dut (
        .c(c), .reset(reset), .iv(iv),
        .bram_we(we), .bram_wsel(wsel), .bram_wa(wa),
        .bram_re(re), .bram_ra(ra), .coefa(coefa), .mac_first(mf),
        .res_v(rv), .res_stage(rs), .ov(ov), .overrun(ovr), .busy(busy)
    );

    halfband_cascade_ctrl #(.NSTAGES(2), .MACLAT(MACLAT)) dut2 (
        .c(c), .reset(reset), .iv(iv),
        .bram_we(we2), .bram_wsel(wsel2), .bram_wa(wa2),
        .bram_re(re2), .bram_ra(ra2), .coefa(coefa2), .mac_first(mf2),
        .res_v(rv2), .res_stage(rs2), .ov(ov2), .overrun(ovr2), .busy(busy2)
    );

    initial c = 1'b0;
    always #5 c = ~c;

    task automatic next_cycle();
        @(posedge c);
        #2;
    endtask

    // Leaves the bench at the start of cycle 0 with reset already low.
    task automatic do_reset();
        reset = 1'b1;
        iv    = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b0;
    endtask

    // Outputs must be zero while reset is held, even with iv high.
    task automatic test_reset();
        logic [30:0] all_out;
        reset = 1'b1;
        iv    = 1'b1;
        next_cycle();
        next_cycle();
        #1;
        all_out = {we, wsel, wa, re, ra, coefa, mf, rv, rs, ov, ovr, busy};
        checks++;
        if (all_out !== 31'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", all_out);
        end
        iv = 1'b0;
        next_cycle();
        reset = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || re !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b re=%b expected 0 0", busy, re);
        end
        next_cycle();
    endtask

    // Two inputs, one stage-0 evaluation, tap addresses and result timing.
    task automatic test_basic();
        logic [8:0] exp_ra [7] = '{9'd7, 9'd9, 9'd11, 9'd12, 9'd13, 9'd15, 9'd1};
        logic [1:0] exp_cf [7] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd2, 2'd1, 2'd0};
        do_reset();
        for (int cy = 0; cy < 22; cy++) begin
            iv = (cy == 0 || cy == 4);
            #1;
            if (cy == 0 || cy == 4) begin
                checks++;
                if (we !== 1'b1 || wsel !== 1'b0 || wa !== 9'(cy / 4)) begin
                    errors++;
                    $display("FAIL basic_ext_write cy%0d: we=%b wsel=%b wa=%0d expected 1 0 %0d",
                             cy, we, wsel, wa, cy / 4);
                end
            end
            if (cy >= 6 && cy <= 12) begin
                checks++;
                if (re !== 1'b1 || ra !== exp_ra[cy-6] || coefa !== exp_cf[cy-6]) begin
                    errors++;
                    $display("FAIL basic_tap cy%0d: re=%b ra=%0d coefa=%0d expected 1 %0d %0d",
                             cy, re, ra, coefa, exp_ra[cy-6], exp_cf[cy-6]);
                end
            end
            if (cy == 5 || cy == 13) begin
                checks++;
                if (re !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_re_idle cy%0d: re=%b expected 0", cy, re);
                end
            end
            if (cy >= 5 && cy <= 13) begin
                checks++;
                if (mf !== (cy == 6)) begin
                    errors++;
                    $display("FAIL basic_mac_first cy%0d: got %b expected %b", cy, mf, cy == 6);
                end
            end
            if (cy >= 13) begin
                checks++;
                if (rv !== (cy == 12 + MACLAT) || ov !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_res_v cy%0d: res_v=%b ov=%b expected %b 0",
                             cy, rv, ov, cy == 12 + MACLAT);
                end
            end
            if (cy == 12 + MACLAT) begin
                checks++;
                if (rs !== 3'd0 || we !== 1'b1 || wsel !== 1'b1 || wa !== 9'd16) begin
                    errors++;
                    $display("FAIL basic_feedback: rs=%0d we=%b wsel=%b wa=%0d expected 0 1 1 16",
                             rs, we, wsel, wa);
                end
            end
            if (cy == 13 + MACLAT) begin
                checks++;
                if (busy !== 1'b0 || we !== 1'b0) begin
                    errors++;
                    $display("FAIL basic_settle: busy=%b we=%b expected 0 0", busy, we);
                end
            end
            next_cycle();
        end
        iv = 1'b0;
    endtask

    // Inputs every 8 cycles: stage-1 evaluation, final-stage ov on dut2,
    // and a stage-2 feedback write on the 4-stage dut.
    task automatic test_cascade();
        int ov_count = 0;
        do_reset();
        for (int cy = 0; cy < 60; cy++) begin
            iv = (cy == 0 || cy == 8 || cy == 16 || cy == 24);
            #1;
            if (ov2 === 1'b1) ov_count++;
            if (cy == 20 || cy == 36) begin
                checks++;
                if (we2 !== 1'b1 || wsel2 !== 1'b1 || wa2 !== (cy == 20 ? 9'd16 : 9'd17)) begin
                    errors++;
                    $display("FAIL cascade_fb_write cy%0d: we=%b wsel=%b wa=%0d expected 1 1 %0d",
                             cy, we2, wsel2, wa2, cy == 20 ? 16 : 17);
                end
            end
            if (cy == 38) begin
                checks++;
                if (ra2 !== 9'd23 || mf2 !== 1'b1 || coefa2 !== 2'd0) begin
                    errors++;
                    $display("FAIL cascade_stage1_t0: ra=%0d mf=%b coefa=%0d expected 23 1 0",
                             ra2, mf2, coefa2);
                end
            end
            if (cy == 44) begin
                checks++;
                if (ra2 !== 9'd17 || re2 !== 1'b1) begin
                    errors++;
                    $display("FAIL cascade_stage1_t6: ra=%0d re=%b expected 17 1", ra2, re2);
                end
            end
            if (cy == 44 + MACLAT) begin
                checks++;
                if (ov2 !== 1'b1 || rv2 !== 1'b1 || rs2 !== 3'd1 || we2 !== 1'b0) begin
                    errors++;
                    $display("FAIL cascade_ov: ov=%b res_v=%b rs=%0d we=%b expected 1 1 1 0",
                             ov2, rv2, rs2, we2);
                end
                checks++;
                if (rv !== 1'b1 || rs !== 3'd1 || ov !== 1'b0 || we !== 1'b1 || wa !== 9'd32) begin
                    errors++;
                    $display("FAIL cascade_4stage: res_v=%b rs=%0d ov=%b we=%b wa=%0d expected 1 1 0 1 32",
                             rv, rs, ov, we, wa);
                end
            end
            next_cycle();
        end
        iv = 1'b0;
        checks++;
        if (ov_count != 1) begin
            errors++;
            $display("FAIL cascade_ov_count: got %0d expected 1", ov_count);
        end
    endtask

    // External write colliding with a stage-0 result defers the feedback.
    task automatic test_back_to_back();
        do_reset();
        for (int cy = 0; cy < 20; cy++) begin
            iv = (cy == 0 || cy == 4 || cy == 12 + MACLAT);
            #1;
            if (cy == 12 + MACLAT) begin
                checks++;
                if (we !== 1'b1 || wsel !== 1'b0 || wa !== 9'd2 || rv !== 1'b1) begin
                    errors++;
                    $display("FAIL collide_ext: we=%b wsel=%b wa=%0d res_v=%b expected 1 0 2 1",
                             we, wsel, wa, rv);
                end
            end
            if (cy == 13 + MACLAT) begin
                checks++;
                if (we !== 1'b1 || wsel !== 1'b1 || wa !== 9'd16 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL collide_deferred: we=%b wsel=%b wa=%0d busy=%b expected 1 1 16 1",
                             we, wsel, wa, busy);
                end
            end
            if (cy == 14 + MACLAT) begin
                checks++;
                if (we !== 1'b0) begin
                    errors++;
                    $display("FAIL collide_after: we=%b expected 0", we);
                end
            end
            next_cycle();
        end
        iv = 1'b0;
    endtask

    // Back-to-back pairs: the third pair finds stage 0 still pending.
    task automatic test_overrun();
        do_reset();
        for (int cy = 0; cy < 70; cy++) begin
            iv = (cy < 32) && (cy % 2 == 0);
            #1;
            if (cy == 10 || cy == 11 || cy == 30 || cy == 69) begin
                checks++;
                if (ovr !== (cy >= 11)) begin
                    errors++;
                    $display("FAIL overrun cy%0d: got %b expected %b", cy, ovr, cy >= 11);
                end
            end
            next_cycle();
        end
        iv    = 1'b0;
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
        #1;
        checks++;
        if (ovr !== 1'b0) begin
            errors++;
            $display("FAIL overrun_clear: got %b expected 0", ovr);
        end
        next_cycle();
    endtask

    // Reset in T3 kills the evaluation; later writes restart at index 0.
    task automatic test_reset_midway();
        logic [30:0] all_out;
        int bad_rv = 0;
        do_reset();
        for (int cy = 0; cy < 30; cy++) begin
            iv    = (cy == 0 || cy == 4 || cy == 20);
            reset = (cy == 9);
            #1;
            if (cy == 9) begin
                checks++;
                if (ra !== 9'd12 || coefa !== 2'd3) begin
                    errors++;
                    $display("FAIL midway_t3: ra=%0d coefa=%0d expected 12 3", ra, coefa);
                end
            end
            if (cy == 10) begin
                all_out = {we, wsel, wa, re, ra, coefa, mf, rv, rs, ov, ovr, busy};
                checks++;
                if (all_out !== 31'd0) begin
                    errors++;
                    $display("FAIL midway_zero: got %h expected 0", all_out);
                end
            end
            if (cy >= 10 && (rv === 1'b1 || (we === 1'b1 && cy != 20))) bad_rv++;
            if (cy == 20) begin
                checks++;
                if (we !== 1'b1 || wsel !== 1'b0 || wa !== 9'd0) begin
                    errors++;
                    $display("FAIL midway_restart: we=%b wsel=%b wa=%0d expected 1 0 0",
                             we, wsel, wa);
                end
            end
            next_cycle();
        end
        iv    = 1'b0;
        reset = 1'b0;
        checks++;
        if (bad_rv != 0) begin
            errors++;
            $display("FAIL midway_no_result: got %0d stray cycles expected 0", bad_rv);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        iv     = 1'b0;
        test_reset();
        test_basic();
        test_cascade();
        test_back_to_back();
        test_overrun();
        test_reset_midway();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
